// File: rtl/sseg_pkg.sv
// sseg_pkg: shared constants and types for the seven-segment scan driver.
//   HEX_SEG      - 16-entry nibble -> active-low a..g pattern (bit 0 = a)
//   SEG_OFF      - all cathodes off
//   AN_OFF       - all anodes off
//   digit_idx_t  - digit slot index 0..3
//   disp_word_t  - 24-bit display word {dp, blank, hex}, matching wr_data[23:0]
//   lead_zero()  - true when digit i (i>0) and every more-significant nibble are 0
package sseg_pkg;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [3:0] AN_OFF  = 4'hF;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef logic [1:0] digit_idx_t;

  typedef struct packed {
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic [15:0] hex;
  } disp_word_t;

  function automatic logic lead_zero(input logic [15:0] hex, input digit_idx_t i);
    return (i != 2'd0) && ((hex >> {i, 2'b00}) == 16'd0);
  endfunction

endpackage

// File: rtl/sseg_scan_driver_if.sv
// sseg_scan_driver_if: CPU-side write port of the display driver.
//   wr_en   - write strobe, already address-qualified
//   wr_data - {ignored[31:24], dp[23:20], blank[19:16], hex[15:0]}
//   master  - the IOBUS decode side; slave - the scan driver
interface sseg_scan_driver_if;
  logic        wr_en;
  logic [31:0] wr_data;

  modport master (output wr_en, output wr_data);
  modport slave  (input  wr_en, input  wr_data);
endinterface

// File: rtl/sseg_hex_decode.sv
// sseg_hex_decode: combinational nibble + decimal point -> active-low cathodes.
//   nibble - hex digit value
//   dp     - 1 = decimal point lit
//   segs   - {dp_n, g..a}, active-low
module sseg_hex_decode
  import sseg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] segs
);

  assign segs = {~dp, HEX_SEG[nibble]};

endmodule

// File: rtl/sseg_scan_driver.sv
// sseg_scan_driver: 4-digit time-multiplexed common-anode display driver.
//   clk, rst_n   - clock, asynchronous active-low reset
//   wr           - write port (sseg_scan_driver_if.slave) into the shadow word
//   segs         - cathodes, active-low, [6:0] = a..g, [7] = dp
//   an           - anodes, active-low, an[i] enables digit i
//   frame_done   - one-cycle pulse on the edge where digit3's slot wraps to digit0
// Parameters: DIG_CYCLES cycles per digit slot, BLANK_CYCLES dark lead-in per slot.
// Optional macro SSEG_LZB_EN: leading-zero blanking of digits 3..1.
module sseg_scan_driver
  import sseg_pkg::*;
#(
  parameter int DIG_CYCLES   = 12500,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  sseg_scan_driver_if.slave        wr,
  output logic [7:0]               segs,
  output logic [3:0]               an,
  output logic                     frame_done
);

  localparam int            CW       = (DIG_CYCLES > 1) ? $clog2(DIG_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIG_CYCLES - 1);

  logic [CW-1:0] cnt, cnt_nxt;
  digit_idx_t    idx, idx_nxt;
  disp_word_t    shadow, active, active_nxt;
  logic          frame_edge;
  logic          dark;
  logic [7:0]    seg_lit;

  // Upper byte of the write word carries no display state.
  logic unused_hi;
  assign unused_hi = &wr.wr_data[31:24];

  // Outputs are computed from the post-edge counter/word so they change on
  // the same edge as the counter that causes them.
  always_comb begin
    cnt_nxt    = cnt + 1'b1;
    idx_nxt    = idx;
    frame_edge = 1'b0;
    if (cnt == CNT_LAST) begin
      cnt_nxt    = '0;
      idx_nxt    = idx + 2'd1;
      frame_edge = (idx == 2'd3);
    end
    // Swap only at the frame edge so a frame is never shown half-old/half-new.
    active_nxt = frame_edge ? shadow : active;
    dark       = (int'(cnt_nxt) < BLANK_CYCLES) || active_nxt.blank[idx_nxt];
`ifdef SSEG_LZB_EN
    dark       = dark || lead_zero(active_nxt.hex, idx_nxt);
`endif
  end

  sseg_hex_decode u_dec (
    .nibble (active_nxt.hex[{idx_nxt, 2'b00} +: 4]),
    .dp     (active_nxt.dp[idx_nxt]),
    .segs   (seg_lit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      idx        <= '0;
      shadow     <= '0;
      active     <= '0;
      segs       <= SEG_OFF;
      an         <= AN_OFF;
      frame_done <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      active     <= active_nxt;
      frame_done <= frame_edge;
      if (wr.wr_en) shadow <= wr.wr_data[23:0];
      if (dark) begin
        segs <= SEG_OFF;
        an   <= AN_OFF;
      end else begin
        segs <= seg_lit;
        an   <= ~(4'b0001 << idx_nxt);
      end
    end
  end

endmodule

// File: tb/tb_sseg_scan_driver.sv
// tb_sseg_scan_driver: scoreboard bench for sseg_scan_driver.
// The driver applies one input set per cycle and pushes the expected
// post-edge outputs, derived from absolute edge count since reset release;
// a negedge monitor pops and compares every cycle.
module tb_sseg_scan_driver;

  localparam int DIG   = 8;
  localparam int BLK   = 2;
  localparam int FRAME = 4 * DIG;

  localparam logic [6:0] HEX_REF [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] segs;
  logic [3:0] an;
  logic       frame_done;

  sseg_scan_driver_if bus ();

  sseg_scan_driver #(.DIG_CYCLES(DIG), .BLANK_CYCLES(BLK)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr         (bus.slave),
    .segs       (segs),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] segs;
    logic [3:0] an;
    logic       fd;
    int         tag;
  } exp_t;

  exp_t        q[$];
  int          errors = 0;
  int          checks = 0;
  int          k;
  logic [23:0] m_shadow, m_active;
  logic [3:0]  last_an;

  // Expected outputs after edge kk since reset release, showing word w.
  function automatic exp_t model_out(input int kk, input logic [23:0] w);
    exp_t       e;
    int         p, d, off;
    logic       dark;
    logic [3:0] nib;
    p    = kk % FRAME;
    d    = p / DIG;
    off  = p % DIG;
    nib  = w[d*4 +: 4];
    dark = (off < BLK) || w[16 + d];
`ifdef SSEG_LZB_EN
    if (d > 0 && (w[15:0] >> (4 * d)) == 16'd0) dark = 1'b1;
`endif
    e.tag = kk;
    e.fd  = (p == 0);
    if (dark) begin
      e.segs = 8'hFF;
      e.an   = 4'hF;
    end else begin
      e.segs = {~w[20 + d], HEX_REF[nib]};
      e.an   = 4'hF & ~(4'b0001 << d);
    end
    return e;
  endfunction

  task automatic drive(input logic wr, input logic [31:0] data);
    exp_t e;
    bus.wr_en   = wr;
    bus.wr_data = data;
    if (!rst_n) begin
      e.segs = 8'hFF; e.an = 4'hF; e.fd = 1'b0; e.tag = -1;
    end else begin
      k++;
      if (k % FRAME == 0) m_active = m_shadow;
      if (wr) m_shadow = data[23:0];
      e = model_out(k, m_active);
    end
    last_an = e.an;
    q.push_back(e);
  endtask

  task automatic step(input logic wr, input logic [31:0] data);
    @(negedge clk); #1;
    drive(wr, data);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 32'h0);
  endtask

  task automatic assert_reset(input int n);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (an !== 4'hF || segs !== 8'hFF || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: segs/an/fd got %h/%h/%b want ff/f/0", segs, an, frame_done);
    end
    drive(1'b0, 32'h0);
    repeat (n - 1) step(1'b0, 32'h0);
  endtask

  task automatic release_reset();
    @(negedge clk); #1;
    rst_n    = 1'b1;
    k        = 0;
    m_shadow = '0;
    m_active = '0;
    drive(1'b0, 32'h0);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (segs !== e.segs || an !== e.an || frame_done !== e.fd) begin
        errors++;
        $display("FAIL scan edge=%0d: segs/an/fd got %h/%h/%b want %h/%h/%b",
                 e.tag, segs, an, frame_done, e.segs, e.an, e.fd);
      end
    end
  end

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_data = 32'h0;
    last_an     = 4'hF;
    k           = 0;
    m_shadow    = '0;
    m_active    = '0;

    assert_reset(3);
    release_reset();
    idle(40);

    // Double buffering: written mid-frame, shown from the next frame.
    step(1'b1, 32'h0000_1234);
    idle(60);

    // Decimal point on digit1, digit0 = F.
    step(1'b1, 32'h0020_00AF);
    idle(64);

    // Blank mask darkens digits 2 and 3.
    step(1'b1, 32'h000C_1234);
    idle(64);

    // Leading-zero cases (behaviour depends on SSEG_LZB_EN).
    step(1'b1, 32'h0000_0005);
    idle(64);
    step(1'b1, 32'h0000_0000);
    idle(64);

    // Write coinciding with the frame edge: old shadow shows one more frame.
    step(1'b1, 32'h00F0_4321);
    while (k % FRAME != FRAME - 1) step(1'b0, 32'h0);
    step(1'b1, 32'h0000_BEEF);
    idle(70);

    // Randomized writes at random times.
    for (int i = 0; i < 20; i++) begin
      idle($urandom_range(0, 40));
      step(1'b1, $urandom);
    end
    idle(70);

    // Reset in the middle of digit2's lit period.
    step(1'b1, 32'h0000_1234);
    idle(40);
    for (int i = 0; i < 200 && last_an != 4'hB; i++) step(1'b0, 32'h0);
    checks++;
    if (last_an !== 4'hB) begin
      errors++;
      $display("FAIL reach_digit2: an got %h want b", last_an);
    end
    assert_reset(2);
    release_reset();
    idle(40);

    @(negedge clk); #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: queue depth got %0d want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
